// File: rtl/dat_mem_arb.sv
// dat_mem_arb: two-port round-robin arbiter and sequencer in front of a
// single-port data memory with combinational read data.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees its one-cycle gnt pulse. At the edge that ends the gnt cycle
// it either drops req or presents its next command. A read returns data on
// rdata with a one-cycle rvalid pulse, one cycle after the grant cycle. A
// write completes silently when the memory latches it at the edge ending the
// grant cycle. rvalid cannot be back-pressured.
module dat_mem_arb #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    // last: port that won the most recent grant (1 after reset, so port 0
    // wins the first tie). rd_pend/rd_port: a read was granted last edge and
    // its data must be captured at this edge for that port.
    logic last;
    logic rd_pend;
    logic rd_port;

    logic elig0;
    logic elig1;
    logic any_elig;
    logic win1;

    // Eligibility masks the request currently being granted; ties go to the
    // port that did not win last time.
    always_comb begin
        elig0    = req0 & ~gnt0;
        elig1    = req1 & ~gnt1;
        any_elig = elig0 | elig1;
        win1     = elig1 & (~elig0 | ~last);
    end

    // Grant register: launch the winner's command to the memory pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            mem_addr   <= '0;
            mem_wr_en  <= 1'b0;
            mem_dat_in <= '0;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
            last       <= 1'b1;
        end else if (any_elig) begin
            gnt0       <= ~win1;
            gnt1       <= win1;
            mem_addr   <= win1 ? addr1 : addr0;
            mem_dat_in <= win1 ? wdata1 : wdata0;
            mem_wr_en  <= win1 ? we1 : we0;
            rd_pend    <= win1 ? ~we1 : ~we0;
            rd_port    <= win1;
            last       <= win1;
        end else begin
            // Address and write data hold; only the strobes drop.
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mem_wr_en <= 1'b0;
            rd_pend   <= 1'b0;
        end
    end

    // Read return: capture memory data for the port whose read was granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd_pend & ~rd_port;
            rvalid1 <= rd_pend & rd_port;
            if (rd_pend && !rd_port) rdata0 <= mem_dat_out;
            if (rd_pend && rd_port)  rdata1 <= mem_dat_out;
        end
    end

endmodule

// File: tb/tb_dat_mem_arb.sv
// tb_dat_mem_arb: directed scenarios plus randomized traffic for
// dat_mem_arb, checked cycle by cycle against a behavioural model and a
// per-port read-data scoreboard.
module tb_dat_mem_arb;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dat_in, mem_dat_out;

    logic [1:0]    cur_req = 2'b00;
    logic [1:0]    cur_we  = 2'b00;
    logic [AW-1:0] cur_addr [2];
    logic [DW-1:0] cur_wdata [2];

    assign req0   = cur_req[0];
    assign req1   = cur_req[1];
    assign we0    = cur_we[0];
    assign we1    = cur_we[1];
    assign addr0  = cur_addr[0];
    assign addr1  = cur_addr[1];
    assign wdata0 = cur_wdata[0];
    assign wdata1 = cur_wdata[1];

    dat_mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in),
        .mem_dat_out(mem_dat_out)
    );

    // ---------------- attached memory (8 x 256, comb read) ----------------
    logic [DW-1:0] tb_mem [256];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) tb_mem[pre_addr] <= pre_data;
        else if (mem_wr_en) tb_mem[mem_addr] <= mem_dat_in;
    end
    assign mem_dat_out = tb_mem[mem_addr];

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [256];
    logic [1:0]    m_gnt;
    logic          m_last;
    logic          m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [1:0]    m_rvalid;
    logic [DW-1:0] m_rdata [2];
    logic          m_pend;
    logic          m_pend_port;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    cmd_t cmd_q0[$];
    cmd_t cmd_q1[$];
    logic rnd_mode = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_gnt = 2'b00; m_last = 1'b1; m_wr_en = 1'b0;
        m_addr = '0; m_din = '0; m_rvalid = 2'b00;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_pend = 1'b0; m_pend_port = 1'b0; m_pend_data = '0;
        exp_q0.delete(); exp_q1.delete();
    endtask

    // One clock edge of the arbiter as seen from its rules: return the read
    // granted last edge, commit the write granted last edge, grant a new
    // access (masked request, alternate on tie).
    task automatic model_edge();
        int w;
        logic [1:0] el;
        for (int p = 0; p < 2; p++) begin
            m_rvalid[p] = m_pend && (int'(m_pend_port) == p);
            if (m_rvalid[p]) m_rdata[p] = m_pend_data;
        end
        if (m_wr_en) ref_mem[m_addr] = m_din;
        el = cur_req & ~m_gnt;
        w = -1;
        if (el[0] && el[1]) w = m_last ? 0 : 1;
        else if (el[0]) w = 0;
        else if (el[1]) w = 1;
        if (w < 0) begin
            m_gnt = 2'b00; m_wr_en = 1'b0; m_pend = 1'b0;
        end else begin
            m_gnt       = (w == 0) ? 2'b01 : 2'b10;
            m_addr      = cur_addr[w];
            m_din       = cur_wdata[w];
            m_wr_en     = cur_we[w];
            m_pend      = !cur_we[w];
            m_pend_port = (w == 1);
            m_last      = (w == 1);
            if (!cur_we[w]) begin
                m_pend_data = ref_mem[cur_addr[w]];
                if (w == 0) exp_q0.push_back(m_pend_data);
                else exp_q1.push_back(m_pend_data);
            end
        end
    endtask

    task automatic check_cycle();
        check("gnt0", gnt0, m_gnt[0]);
        check("gnt1", gnt1, m_gnt[1]);
        check("rvalid0", rvalid0, m_rvalid[0]);
        check("rvalid1", rvalid1, m_rvalid[1]);
        check("rdata0", rdata0, m_rdata[0]);
        check("rdata1", rdata1, m_rdata[1]);
        check("mem_wr_en", mem_wr_en, m_wr_en);
        check("mem_addr", mem_addr, m_addr);
        check("mem_dat_in", mem_dat_in, m_din);
        if (rvalid0) begin
            check("rd0_pending", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) check("rd0_sb", rdata0, exp_q0.pop_front());
        end
        if (rvalid1) begin
            check("rd1_pending", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) check("rd1_sb", rdata1, exp_q1.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'($urandom_range(0, 7));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic push_cmd(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        if (p == 0) cmd_q0.push_back(c);
        else cmd_q1.push_back(c);
    endtask

    // Requester behaviour: retire a command on its grant, then present the
    // next queued (or random) command or leave req low.
    task automatic driver_update();
        cmd_t c;
        logic got;
        for (int p = 0; p < 2; p++) begin
            if (cur_req[p] && m_gnt[p]) cur_req[p] = 1'b0;
            if (!cur_req[p]) begin
                got = 1'b0;
                c = '0;
                if (p == 0 && cmd_q0.size() > 0) begin
                    c = cmd_q0.pop_front(); got = 1'b1;
                end else if (p == 1 && cmd_q1.size() > 0) begin
                    c = cmd_q1.pop_front(); got = 1'b1;
                end else if (rnd_mode && $urandom_range(0, 3) != 0) begin
                    c.we = 1'($urandom_range(0, 1));
                    c.addr = rand_addr();
                    c.data = 8'($urandom_range(0, 255));
                    got = 1'b1;
                end
                if (got) begin
                    cur_req[p] = 1'b1; cur_we[p] = c.we;
                    cur_addr[p] = c.addr; cur_wdata[p] = c.data;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
        driver_update();
    endtask

    task automatic drain();
        int n;
        logic busy;
        n = 0;
        driver_update();
        busy = (cur_req != 2'b00) || (cmd_q0.size() > 0) || (cmd_q1.size() > 0);
        while (busy && n < 300) begin
            tick();
            n++;
            busy = (cur_req != 2'b00) || (cmd_q0.size() > 0) || (cmd_q1.size() > 0);
        end
        check("drain_done", busy, 0);
        repeat (3) tick();
    endtask

    // Reset asserted mid-cycle, checked immediately, released at a negedge.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        cur_req = 2'b00;
        cmd_q0.delete(); cmd_q1.delete();
        model_reset();
        #1;
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] v;
        reset = 1'b1;
        cur_addr[0] = '0; cur_addr[1] = '0;
        cur_wdata[0] = '0; cur_wdata[1] = '0;
        model_reset();

        // Preload memory and reference with known values at key addresses.
        @(negedge clk);
        pre_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 8'h00) v = 8'h5A;
            else if (i == 8'hFF) v = 8'hC3;
            else if (i == 8'h20) v = 8'h42;
            else v = 8'($urandom_range(0, 255));
            pre_addr = 8'(i); pre_data = v; ref_mem[i] = v;
            @(negedge clk);
        end
        pre_en = 1'b0;
        check_cycle();
        reset = 1'b0;

        // Port 0 write then read.
        push_cmd(0, 1'b1, 8'h10, 8'hA5);
        push_cmd(0, 1'b0, 8'h10, 8'h00);
        drain();
        check("t1_rdata0", rdata0, 8'hA5);

        // Tie straight after reset: 0,1,0,1...
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'b0, 8'(8'h01 + i), 8'h00);
            push_cmd(1, 1'b0, 8'(8'h05 + i), 8'h00);
        end
        drain();

        // Port 1 continuous reads of 0x00 then 0xFF.
        push_cmd(1, 1'b0, 8'h00, 8'h00);
        push_cmd(1, 1'b0, 8'hFF, 8'h00);
        drain();
        check("t3_rdata1", rdata1, 8'hC3);

        // Cross-port read-after-write on 0xFF.
        push_cmd(1, 1'b1, 8'hFF, 8'h33);
        driver_update();
        tick();
        push_cmd(0, 1'b0, 8'hFF, 8'h00);
        drain();
        check("t4_rdata0", rdata0, 8'h33);

        // Reset during a write grant: the write must be dropped.
        push_cmd(0, 1'b1, 8'h20, 8'h77);
        driver_update();
        tick();
        check("t5_gnt0", gnt0, 1);
        check("t5_wr_en", mem_wr_en, 1);
        pulse_reset();
        push_cmd(0, 1'b0, 8'h20, 8'h00);
        push_cmd(1, 1'b0, 8'h21, 8'h00);
        driver_update();
        tick();
        check("t5_first_gnt0", gnt0, 1);
        drain();
        check("t5_rdata0", rdata0, 8'h42);

        // Randomized traffic on both ports.
        rnd_mode = 1'b1;
        repeat (600) tick();
        rnd_mode = 1'b0;
        drain();

        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
